mem_arbiter: RTL and testbench

Single-port program-memory arbiter for the bali core. It shares one synchronous 256×8 memory between the CPU instruction-fetch port and a data/loader port that writes programs and reads constants. Fetch has priority, and a starvation counter guarantees the data port a slot. The block sits between `cpu` and the memory array, replacing the direct `mem[pc]` lookup.

---
 rtl/bali_pkg.sv | 16 +
 rtl/mem_arbiter.sv | 98 +++++++++
 tb/tb_mem_arbiter.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/bali_pkg.sv
// Shared types for the bali core memory subsystem: address/data words,
// response-owner encoding and the starvation counter width.
package bali_pkg;

    localparam int STARVE_W = 4;

    typedef logic [7:0] addr_t;
    typedef logic [7:0] data_t;

    typedef enum logic [1:0] {
        OWN_NONE  = 2'd0,
        OWN_FETCH = 2'd1,
        OWN_DATA  = 2'd2
    } mem_owner_t;

endpackage

// File: rtl/mem_arbiter.sv
// Single-port program-memory arbiter: fetch has priority, a saturating
// starvation counter guarantees the data/loader port a slot.
module mem_arbiter
    import bali_pkg::*;
#(
    parameter int ADDR_W     = 8,
    parameter int DATA_W     = 8,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              f_req,
    input  logic [ADDR_W-1:0] f_addr,
    output logic              f_gnt,
    output logic              f_rvalid,
    output logic [DATA_W-1:0] f_rdata,

    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,

    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam logic [STARVE_W-1:0] STARVE_LIM = STARVE_W'(STARVE_MAX);

    logic [STARVE_W-1:0] starve_q, starve_d;
    mem_owner_t          owner_q,  owner_d;

    // Grant is combinational from the requests and registered state.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first,
        // otherwise an unassigned path infers a latch.
        f_gnt = 1'b0;
        d_gnt = 1'b0;
        if (!rst) begin
            if (f_req && d_req) begin
                if (starve_q >= STARVE_LIM) begin
                    d_gnt = 1'b1;
                end else begin
                    f_gnt = 1'b1;
                end
            end else begin
                f_gnt = f_req;
                d_gnt = d_req;
            end
        end
    end

    always_comb begin
        starve_d = starve_q;
        if (!d_req || d_gnt) begin
            starve_d = '0;
        end else if (f_gnt && (starve_q < STARVE_LIM)) begin
            starve_d = starve_q + STARVE_W'(1);
        end

        owner_d = OWN_NONE;
        if (f_gnt) begin
            owner_d = OWN_FETCH;
        end else if (d_gnt && !d_we) begin
            owner_d = OWN_DATA;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values regardless of statement order.
        if (rst) begin
            starve_q <= '0;
            owner_q  <= OWN_NONE;
        end else begin
            starve_q <= starve_d;
            owner_q  <= owner_d;
        end
    end

    assign mem_en    = f_gnt | d_gnt;
    assign mem_we    = d_gnt & d_we;
    assign mem_addr  = d_gnt ? d_addr : f_addr;
    assign mem_wdata = d_wdata;

    // Reset in the response cycle swallows the pending read.
    assign f_rvalid = !rst && (owner_q == OWN_FETCH);
    assign d_rvalid = !rst && (owner_q == OWN_DATA);
    assign f_rdata  = mem_rdata;
    assign d_rdata  = mem_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomised and directed bench for mem_arbiter with a write-first memory,
// a reference arbitration model and a read-response scoreboard.
module tb_mem_arbiter;
    import bali_pkg::*;

    localparam int SM = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       f_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
    logic [7:0] f_addr = '0, d_addr = '0, d_wdata = '0;
    logic       f_gnt, f_rvalid, d_gnt, d_rvalid;
    logic [7:0] f_rdata, d_rdata;
    logic       mem_en, mem_we;
    logic [7:0] mem_addr, mem_wdata, mem_rdata;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(8), .DATA_W(8), .STARVE_MAX(SM)) dut (
        .clk(clk), .rst(rst),
        .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt),
        .f_rvalid(f_rvalid), .f_rdata(f_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    // Synchronous write-first 256x8 memory.
    logic [7:0] mem [256];
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) begin
                mem[mem_addr] <= mem_wdata;
                mem_rdata     <= mem_wdata;
            end else begin
                mem_rdata     <= mem[mem_addr];
            end
        end
    end

    typedef struct {
        bit         is_data;
        logic [7:0] data;
        int         tag;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] ref_mem [256];
    int         fetch_streak = 0;   // fetch grants data has sat through
    int         cyc = 0;
    int         checks = 0;
    int         errors = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One bus cycle: drive after the edge, check grants and memory port at
    // the falling edge, queue the expected read responses.
    task automatic bus_cycle(input bit r, input bit fr, input logic [7:0] fa,
                             input bit dr, input bit dw, input logic [7:0] da,
                             input logic [7:0] dwd);
        bit eg_f, eg_d;
        @(posedge clk);
        #1;
        rst = r; f_req = fr; f_addr = fa;
        d_req = dr; d_we = dw; d_addr = da; d_wdata = dwd;
        if (r) exp_q.delete();
        eg_f = 1'b0;
        eg_d = 1'b0;
        if (!r) begin
            if (fr && dr) begin
                if (fetch_streak >= SM) eg_d = 1'b1;
                else                    eg_f = 1'b1;
            end else begin
                eg_f = fr;
                eg_d = dr;
            end
        end
        @(negedge clk);
        check("starve_cnt", 32'(dut.starve_q), 32'(fetch_streak));
        check("f_gnt",  32'(f_gnt),  32'(eg_f));
        check("d_gnt",  32'(d_gnt),  32'(eg_d));
        check("mem_en", 32'(mem_en), 32'(eg_f | eg_d));
        check("mem_we", 32'(mem_we), 32'(eg_d & dw));
        if (eg_f) check("mem_addr_f", 32'(mem_addr), 32'(fa));
        if (eg_d) check("mem_addr_d", 32'(mem_addr), 32'(da));
        if (eg_d && dw) check("mem_wdata", 32'(mem_wdata), 32'(dwd));

        if (eg_f) exp_q.push_back('{is_data: 1'b0, data: ref_mem[fa], tag: cyc});
        if (eg_d && !dw) exp_q.push_back('{is_data: 1'b1, data: ref_mem[da], tag: cyc});
        if (eg_d && dw) ref_mem[da] = dwd;

        if (r || !dr || eg_d) fetch_streak = 0;
        else if (eg_f)        fetch_streak = (fetch_streak + 1 > SM) ? SM : fetch_streak + 1;
    endtask

    // Response monitor: every rvalid must match the oldest queued read,
    // one cycle after its grant, on the right port.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #1;
            if (f_rvalid || d_rvalid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL spurious_rvalid: got f=%0b d=%0b expected none (cycle %0d)",
                             f_rvalid, d_rvalid, cyc);
                end else begin
                    e = exp_q.pop_front();
                    check("rvalid_port", {30'd0, f_rvalid, d_rvalid}, e.is_data ? 32'd1 : 32'd2);
                    check("rdata", 32'(e.is_data ? d_rdata : f_rdata), 32'(e.data));
                    check("rvalid_latency", 32'(cyc - e.tag), 32'd1);
                end
            end else if (exp_q.size() > 0 && exp_q[0].tag < cyc) begin
                e = exp_q.pop_front();
                checks++;
                errors++;
                $display("FAIL missing_rvalid: got none expected %s data %0h (cycle %0d)",
                         e.is_data ? "data" : "fetch", e.data, cyc);
            end
        end
    end

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem[i]     = 8'(i + 8'h10);
            ref_mem[i] = 8'(i + 8'h10);
        end

        bus_cycle(1, 0, 8'h00, 0, 0, 8'h00, 8'h00);
        bus_cycle(1, 0, 8'h00, 0, 0, 8'h00, 8'h00);

        // Fetch only, pc 0..5.
        for (int i = 0; i < 6; i++) bus_cycle(0, 1, 8'(i), 0, 0, 8'h00, 8'h00);
        bus_cycle(0, 0, 8'h00, 0, 0, 8'h00, 8'h00);

        // Data write then read-back.
        bus_cycle(0, 0, 8'h00, 1, 1, 8'h20, 8'hA5);
        bus_cycle(0, 0, 8'h00, 1, 0, 8'h20, 8'h00);
        bus_cycle(0, 0, 8'h00, 0, 0, 8'h00, 8'h00);

        // Starvation: both ports requesting continuously.
        for (int i = 0; i < 15; i++) bus_cycle(0, 1, 8'(i), 1, 0, 8'h30, 8'h00);

        // Data drops early after two fetch grants.
        bus_cycle(0, 0, 8'h00, 0, 0, 8'h00, 8'h00);
        for (int i = 0; i < 2; i++) bus_cycle(0, 1, 8'(i), 1, 0, 8'h31, 8'h00);
        bus_cycle(0, 1, 8'h02, 0, 0, 8'h31, 8'h00);
        for (int i = 0; i < 6; i++) bus_cycle(0, 1, 8'(i + 3), 1, 0, 8'h31, 8'h00);

        // Reset mid-read, with a write attempted during reset.
        bus_cycle(0, 1, 8'h07, 0, 0, 8'h00, 8'h00);
        bus_cycle(1, 1, 8'h08, 1, 1, 8'h20, 8'h5A);
        bus_cycle(1, 1, 8'h08, 1, 1, 8'h20, 8'h5A);
        bus_cycle(0, 0, 8'h00, 1, 0, 8'h20, 8'h00);
        bus_cycle(0, 1, 8'h09, 0, 0, 8'h00, 8'h00);

        // Randomised traffic on a narrow address window to exercise RAW.
        for (int i = 0; i < 1000; i++) begin
            bus_cycle(($urandom_range(0, 63) == 0),
                      ($urandom_range(0, 9) < 7),
                      8'($urandom_range(0, 15)),
                      ($urandom_range(0, 1) == 1),
                      ($urandom_range(0, 1) == 1),
                      8'($urandom_range(0, 15)),
                      8'($urandom));
        end

        bus_cycle(0, 0, 8'h00, 0, 0, 8'h00, 8'h00);
        bus_cycle(0, 0, 8'h00, 0, 0, 8'h00, 8'h00);
        check("drained", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
